// File: rtl/rat_intr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rat_intr_ctrl
//  Description : Interrupt controller in front of the MCU control unit.
//                Synchronises and edge-detects the external sources, latches
//                them as pending, applies the software mask and holds the
//                global interrupt-enable flag. A request is raised only in
//                an EXEC_PH cycle and retired on the interrupt-cycle ack.
//                Optional macro RAT_INTR_RR_PRIO_EN selects round-robin
//                priority instead of fixed lowest-index priority.
//  Revision    : 1.0  initial release
// ============================================================================
module rat_intr_ctrl #(
    parameter int NUM_SRC     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic [NUM_SRC-1:0] IRQ_IN,
    input  logic               EXEC_PH,
    input  logic               I_SET,
    input  logic               I_CLR,
    input  logic               INT_ACK,
    input  logic               MASK_WE,
    input  logic [NUM_SRC-1:0] MASK_DIN,
    output logic               INT_R_MCU,
    output logic [2:0]         INT_ID,
    output logic               I_FLAG,
    output logic [NUM_SRC-1:0] PENDING,
    output logic [NUM_SRC-1:0] MASK
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARM      = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
    logic [NUM_SRC-1:0] sync_d [SYNC_STAGES];
    logic [NUM_SRC-1:0] delay_q, delay_d;
    logic [NUM_SRC-1:0] edge_q, edge_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic               i_flag_q, i_flag_d;
    logic [2:0]         int_id_q, int_id_d;

    logic [NUM_SRC-1:0] w_req;
    logic [NUM_SRC-1:0] w_clr;
    logic               w_eligible;
    logic               w_ack;
    logic               w_fire;
    logic [2:0]         w_win_lo;
    logic [2:0]         w_win;

    assign w_req      = pending_q & mask_q;
    assign w_eligible = (|w_req) & i_flag_q;
    // Ack only counts while a request is outstanding; elsewhere it is ignored.
    assign w_ack      = (state_q == ST_WAIT_ACK) & INT_ACK;
    assign w_fire     = (state_q == ST_ARM) & EXEC_PH & w_eligible;

    // Synchroniser shift chain, delay flop and registered rising-edge pulse.
    always_comb begin
        sync_d[0] = IRQ_IN;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
        delay_d = sync_q[SYNC_STAGES-1];
        edge_d  = sync_q[SYNC_STAGES-1] & ~delay_q;
    end

    // Fixed priority: lowest enabled pending index.
    always_comb begin
        w_win_lo = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_win_lo = 3'(i);
            end
        end
    end

`ifdef RAT_INTR_RR_PRIO_EN
    logic [2:0] last_id_q, last_id_d;
    logic [2:0] w_win_hi;
    logic       w_hi_found;

    // Round robin: lowest requester above the last serviced index, else wrap.
    always_comb begin
        w_win_hi   = '0;
        w_hi_found = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_req[i] && (3'(i) > last_id_q)) begin
                w_win_hi   = 3'(i);
                w_hi_found = 1'b1;
            end
        end
        w_win     = w_hi_found ? w_win_hi : w_win_lo;
        last_id_d = w_ack ? int_id_q : last_id_q;
    end

    // Pointer to the most recently acknowledged source.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            last_id_q <= 3'(NUM_SRC - 1);
        end else begin
            last_id_q <= last_id_d;
        end
    end
`else
    assign w_win = w_win_lo;
`endif

    // Next-state for pending, mask, I flag, latched ID and the request FSM.
    always_comb begin
        w_clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_clr[i] = w_ack & (int_id_q == 3'(i));
        end
        // A new edge in the clear cycle takes precedence over the clear.
        pending_d = (pending_q & ~w_clr) | edge_q;
        mask_d    = MASK_WE ? MASK_DIN : mask_q;

        i_flag_d = i_flag_q;
        if (w_ack) begin
            i_flag_d = 1'b0;
        end else if (I_CLR) begin
            i_flag_d = 1'b0;
        end else if (I_SET) begin
            i_flag_d = 1'b1;
        end

        int_id_d = w_fire ? w_win : int_id_q;

        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (w_eligible) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (!w_eligible) begin
                    state_d = ST_IDLE;
                end else if (EXEC_PH) begin
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (INT_ACK) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            delay_q   <= '0;
            edge_q    <= '0;
            pending_q <= '0;
            mask_q    <= '1;
            i_flag_q  <= 1'b0;
            int_id_q  <= '0;
            state_q   <= ST_IDLE;
        end else begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
            delay_q   <= delay_d;
            edge_q    <= edge_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            i_flag_q  <= i_flag_d;
            int_id_q  <= int_id_d;
            state_q   <= state_d;
        end
    end

    assign INT_R_MCU = w_fire;
    assign INT_ID    = int_id_q;
    assign I_FLAG    = i_flag_q;
    assign PENDING   = pending_q;
    assign MASK      = mask_q;

endmodule
`default_nettype wire

// File: tb/tb_rat_intr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rat_intr_ctrl
//  Description : Scoreboard bench for rat_intr_ctrl: directed scenarios plus
//                randomized traffic against a behavioural reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rat_intr_ctrl;
    localparam int N = 4;
    localparam int S = 2;
    localparam int M_IDLE = 0;
    localparam int M_ARM  = 1;
    localparam int M_WAIT = 2;

    logic         CLK = 1'b0;
    logic         RESET_N = 1'b0;
    logic [N-1:0] IRQ_IN = '0;
    logic         EXEC_PH = 1'b0;
    logic         I_SET = 1'b0;
    logic         I_CLR = 1'b0;
    logic         INT_ACK = 1'b0;
    logic         MASK_WE = 1'b0;
    logic [N-1:0] MASK_DIN = '0;
    logic         INT_R_MCU;
    logic [2:0]   INT_ID;
    logic         I_FLAG;
    logic [N-1:0] PENDING;
    logic [N-1:0] MASK;

    always #5 CLK = ~CLK;

    rat_intr_ctrl #(.NUM_SRC(N), .SYNC_STAGES(S)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .IRQ_IN(IRQ_IN), .EXEC_PH(EXEC_PH),
        .I_SET(I_SET), .I_CLR(I_CLR), .INT_ACK(INT_ACK), .MASK_WE(MASK_WE),
        .MASK_DIN(MASK_DIN), .INT_R_MCU(INT_R_MCU), .INT_ID(INT_ID),
        .I_FLAG(I_FLAG), .PENDING(PENDING), .MASK(MASK)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [N-1:0] pend;
        logic [N-1:0] mask;
        logic         iflag;
        logic         req;
    } stat_t;

    stat_t stat_q[$];
    int    id_q[$];

    // Reference model state
    logic [N-1:0] m_pend, m_mask;
    logic         m_iflag;
    int           m_st, m_id, m_last;
    logic [N-1:0] m_hist[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic void model_reset();
        m_pend = '0; m_mask = '1; m_iflag = 1'b0;
        m_st = M_IDLE; m_id = 0; m_last = N - 1;
        m_hist.delete();
        for (int i = 0; i < S + 2; i++) m_hist.push_back('0);
    endfunction

    // Winner: first requester found scanning upward from the start index.
    function automatic int pick(input logic [N-1:0] r);
        int start;
`ifdef RAT_INTR_RR_PRIO_EN
        start = (m_last + 1) % N;
`else
        start = 0;
`endif
        for (int k = 0; k < N; k++) if (r[(start + k) % N]) return (start + k) % N;
        return 0;
    endfunction

    // One clock of stimulus: drive at the falling edge, predict, advance model.
    task automatic step(input logic rstn, input logic [N-1:0] irq, input logic ex,
                        input logic iset, input logic iclr, input logic ack,
                        input logic we, input logic [N-1:0] din);
        logic [N-1:0] avail, ev, clr;
        logic elig, req, ack_ok;
        int win;
        stat_t e;
        @(negedge CLK);
        RESET_N = rstn; IRQ_IN = irq; EXEC_PH = ex; I_SET = iset; I_CLR = iclr;
        INT_ACK = ack; MASK_WE = we; MASK_DIN = din;
        if (!rstn) begin
            model_reset();
            e.pend = m_pend; e.mask = m_mask; e.iflag = m_iflag; e.req = 1'b0;
            stat_q.push_back(e);
            return;
        end
        avail = m_pend & m_mask;
        elig  = (avail != '0) && m_iflag;
        req   = (m_st == M_ARM) && ex && elig;
        win   = pick(avail);
        e.pend = m_pend; e.mask = m_mask; e.iflag = m_iflag; e.req = req;
        stat_q.push_back(e);
        if (req) id_q.push_back(win);
        // A rise sampled S+1 clocks ago becomes a pending event on this edge.
        ev = m_hist[1] & ~m_hist[0];
        m_hist.push_back(irq);
        void'(m_hist.pop_front());
        ack_ok = (m_st == M_WAIT) && ack;
        clr = '0;
        if (ack_ok) clr[m_id] = 1'b1;
        m_pend = (m_pend & ~clr) | ev;
        if (we) m_mask = din;
        if (ack_ok) m_iflag = 1'b0;
        else if (iclr) m_iflag = 1'b0;
        else if (iset) m_iflag = 1'b1;
        case (m_st)
            M_IDLE: if (elig) m_st = M_ARM;
            M_ARM: begin
                if (!elig) m_st = M_IDLE;
                else if (ex) begin m_st = M_WAIT; m_id = win; end
            end
            default: if (ack) begin m_last = m_id; m_st = M_IDLE; end
        endcase
    endtask

    task automatic idle(input int n, input logic [N-1:0] irq);
        for (int i = 0; i < n; i++) step(1'b1, irq, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic run_to_wait(input logic [N-1:0] irq);
        for (int i = 0; i < 24 && m_st != M_WAIT; i++)
            step(1'b1, irq, (i % 2) == 1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        if (m_st != M_WAIT) begin
            n_checks++;
            $display("FAIL reach_wait: got state %0d required %0d", m_st, M_WAIT);
        end
    endtask

    // Monitor: compares status every cycle and pops an expected ID per request.
    initial begin : monitor
        stat_t e;
        int    idexp;
        bit    idchk;
        idchk = 1'b0; idexp = 0;
        forever begin
            @(negedge CLK); #2;
            if (idchk) begin
                if (RESET_N) chk("int_id", 32'(INT_ID), 32'(idexp));
                idchk = 1'b0;
            end
            if (stat_q.size() != 0) begin
                e = stat_q.pop_front();
                chk("status", 32'({PENDING, MASK, I_FLAG, INT_R_MCU}), 32'(e));
                if (INT_R_MCU) begin
                    if (id_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL request: got INT_R_MCU=1 required no request");
                    end else begin
                        idexp = id_q.pop_front();
                        idchk = 1'b1;
                    end
                end
            end
        end
    end

    initial begin : stim
        int exp_a, exp_b;
        logic rstn, ack;
        logic [N-1:0] irq;
        // Reset state
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        #2;
        chk("rst_pending", 32'(PENDING), 32'h0);
        chk("rst_mask", 32'(MASK), 32'hF);
        chk("rst_iflag", 32'(I_FLAG), 32'h0);
        chk("rst_int_id", 32'(INT_ID), 32'h0);
        chk("rst_req", 32'(INT_R_MCU), 32'h0);

        // 1: single source, latency, ack clears pending and I
        idle(1, '0);
        step(1'b1, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        idle(4, 4'b0100);
        #2 chk("t1_pend_early", 32'(PENDING), 32'h0);
        idle(1, 4'b0100);
        #2 chk("t1_pend_latency", 32'(PENDING), 32'h4);
        run_to_wait(4'b0100);
        idle(1, 4'b0100);
        #2 chk("t1_int_id", 32'(INT_ID), 32'd2);
        step(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        idle(1, 4'b0100);
        #2 chk("t1_pend_after_ack", 32'(PENDING), 32'h0);
        chk("t1_iflag_after_ack", 32'(I_FLAG), 32'h0);

        // 2: simultaneous sources 0 and 3
`ifdef RAT_INTR_RR_PRIO_EN
        exp_a = 3; exp_b = 0;
`else
        exp_a = 0; exp_b = 3;
`endif
        idle(4, '0);
        step(1'b1, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        run_to_wait(4'b1001);
        idle(1, 4'b1001);
        #2 chk("t2_first_id", 32'(INT_ID), 32'(exp_a));
        step(1'b1, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        step(1'b1, 4'b1001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        run_to_wait(4'b1001);
        idle(1, 4'b1001);
        #2 chk("t2_second_id", 32'(INT_ID), 32'(exp_b));
        step(1'b1, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);

        // 3: masked source still latches pending but does not request
        step(1'b1, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1110);
        idle(3, '0);
        for (int i = 0; i < 8; i++) step(1'b1, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        #2 chk("t3_pend_masked", 32'(PENDING), 32'h1);
        chk("t3_mask", 32'(MASK), 32'hE);
        step(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1111);
        run_to_wait(4'b0001);
        idle(1, 4'b0001);
        #2 chk("t3_int_id", 32'(INT_ID), 32'd0);
        step(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);

        // 4: I_CLR priority, and I_CLR while armed withdraws the request
        step(1'b1, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        idle(1, '0);
        #2 chk("t4_iflag_both", 32'(I_FLAG), 32'h0);
        step(1'b1, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 12 && m_st != M_ARM; i++) idle(1, 4'b0010);
        step(1'b1, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 6; i++) step(1'b1, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        #2 chk("t4_pend_kept", 32'(PENDING), 32'h2);
        chk("t4_iflag", 32'(I_FLAG), 32'h0);

        // 5: re-rise of source 1 whose edge lands on its own ack cycle
        step(1'b1, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        run_to_wait(4'b0010);
        idle(2, '0);
        idle(3, 4'b0010);
        step(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        idle(1, 4'b0010);
        #2 chk("t5_pend_survives", 32'(PENDING), 32'h2);
        chk("t5_iflag", 32'(I_FLAG), 32'h0);
        step(1'b1, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        run_to_wait(4'b0010);
        idle(1, 4'b0010);
        #2 chk("t5_second_id", 32'(INT_ID), 32'd1);
        step(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);

        // 6: asynchronous reset while waiting for ack; later ack is ignored
        step(1'b1, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        idle(3, '0);
        run_to_wait(4'b0100);
        idle(1, 4'b0100);
        step(1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        #2 chk("t6_rst_req", 32'(INT_R_MCU), 32'h0);
        chk("t6_rst_pend", 32'(PENDING), 32'h0);
        chk("t6_rst_iflag", 32'(I_FLAG), 32'h0);
        chk("t6_rst_id", 32'(INT_ID), 32'h0);
        chk("t6_rst_mask", 32'(MASK), 32'hF);
        step(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        idle(4, 4'b0100);
        #2 chk("t6_iflag_after", 32'(I_FLAG), 32'h0);

        // Randomized traffic
        irq = '0;
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < N; b++) if ($urandom_range(0, 7) == 0) irq[b] = ~irq[b];
            rstn = ($urandom_range(0, 499) != 0);
            ack  = (m_st == M_WAIT) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            step(rstn, irq, $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 9) == 0, ack, $urandom_range(0, 15) == 0, N'($urandom));
        end
        idle(5, irq);
        #3 chk("req_queue_empty", 32'(id_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
